shift_frame_ctrl: RTL

//   Sequencer for the left-shift (insert-at-LSB) serial register. It turns a

---
 rtl/shift_frame_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_frame_ctrl.sv
// Serial-to-parallel frame sequencer.
// On start it shifts WIDTH bits from d_in into a left-shift register (new bit
// at the LSB). It then presents the frame on d_out with d_valid until the
// consumer takes it with out_ready.
//
// Handshake: the frame transfers in any cycle where d_valid=1 and
// out_ready=1, sampled at the same posedge. d_out is stable while d_valid=1,
// and it keeps its value after the handoff until the next frame completes.
module shift_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             d_in,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic             busy,
    output logic             shift_en,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             last_bit;
    logic             accept;
    logic             overrun_set;

    assign sr_nxt   = {sr[WIDTH-2:0], d_in};
    assign last_bit = (bit_cnt == LAST_BIT);

    // Next-state decode, status outputs and handshake/overrun qualifiers
    always_comb begin
        state_nxt   = IDLE;
        busy        = 1'b0;
        shift_en    = 1'b0;
        d_valid     = 1'b0;
        accept      = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = start ? SHIFT : IDLE;
            end
            SHIFT: begin
                busy        = 1'b1;
                shift_en    = 1'b1;
                overrun_set = start;
                state_nxt   = last_bit ? HOLD : SHIFT;
            end
            HOLD: begin
                busy        = 1'b1;
                d_valid     = 1'b1;
                accept      = out_ready;
                // A start that arrives with the handoff begins the next frame.
                // Any other start while the frame is held is an overrun.
                overrun_set = start & ~out_ready;
                if (out_ready) begin
                    state_nxt = start ? SHIFT : IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, shift datapath, frame capture, handoff counter and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sr        <= '0;
            d_out     <= '0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (state == SHIFT) begin
                sr <= sr_nxt;
                if (last_bit) begin
                    d_out   <= sr_nxt;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                bit_cnt <= '0;
            end

            if (accept) begin
                frame_cnt <= frame_cnt + 1'b1;
            end

            // If a new overrun and a clear arrive in the same cycle, the set wins.
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
